dvp_rgb565_capture: RTL and testbench
=====================================

// Module: dvp_rgb565_capture
// PURPOSE
//  Front-end capture stage of the ISP pipeline. Samples the camera DVP bus (8-bit data, href, vsync)
//  and packs byte pairs into RGB565 pixels. Emits a Din/dataEn-style stream that feeds the downstream
//  pixel stages (bypass/processing) directly.
//  Discards the power-up partial frame and FRAME_SKIP settling frames. Reports per-line and per-frame
//  geometry errors.
// PARAMETERS
//  FRAME_SKIP  10   complete frames discarded after reset before capture may start (0 = none)
//  H_ACTIVE    640  expected pixels (byte pairs) per href-high line
//  V_ACTIVE    480  expected href-high lines per frame
//  BYTE_ORDER  0    0: first byte of pair -> Dout[15:8]; 1: first byte -> Dout[7:0]
// PORTS
//  clk          in   1   camera pixel clock (PCLK); all logic on posedge
//  rst_n        in   1   reset: asynchronous, active-low
//  cam_vsync    in   1   frame sync, active-high pulse in vertical blanking
//  cam_href     in   1   line valid, high while bytes are valid
//  cam_data     in   8   pixel byte
//  cap_en       in   1   capture request; sampled only at frame boundaries
//  Dout         out  16  packed RGB565 pixel; 0 whenever outEn=0
//  outEn        out  1   one-cycle pixel valid strobe
//  frame_start  out  1   one-cycle pulse: an ACTIVE frame begins
//  frame_done   out  1   one-cycle pulse: an ACTIVE frame ended
//  line_err     out  1   one-cycle pulse: bad line length or odd byte count
//  frame_err    out  1   one-cycle pulse: line count != V_ACTIVE at end of ACTIVE frame
//  frame_cnt    out  16  completed ACTIVE frames; wraps 0xFFFF -> 0
// BEHAVIOUR
//  - Input stage: cam_* registered once (vs_d, href_d, data_d); vs_d2 holds the previous vs_d.
//    vs_rise = vs_d & ~vs_d2 and marks the frame boundary. href_fall is detected likewise from href_d.
//  - Reset state: all outputs 0. State WAIT_VS; byte phase, pix_cnt, line_cnt, skip_cnt all 0.
//  - FSM transitions:
//      WAIT_VS -> SKIP on first vs_rise; goes direct to ARMED if FRAME_SKIP=0.
//      SKIP: skip_cnt++ per vs_rise; -> ARMED on the vs_rise where skip_cnt==FRAME_SKIP-1.
//      ARMED: on vs_rise with cap_en=1 -> ACTIVE, pulse frame_start, clear line_cnt.
//      ACTIVE: on vs_rise, pulse frame_done, frame_cnt++, check line count.
//        If cap_en=1: stay ACTIVE, pulse frame_start in the same cycle, clear line_cnt.
//        If cap_en=0: -> ARMED.
//    cap_en changes mid-frame have no effect until the next vs_rise (frame-atomic).
//  - Packing: active only in ACTIVE. While href_d=1, the phase bit toggles per cycle.
//    Phase 0 latches data_d as the first byte.
//    Phase 1 registers {first,data_d} (BYTE_ORDER=0) or {data_d,first} (BYTE_ORDER=1) into Dout,
//    with outEn=1 the next cycle.
//    Latency: outEn is high exactly 2 clk after the second byte of the pair is on cam_data.
//    The phase bit clears whenever href_d=0, so each line starts on phase 0.
//  - Counters and error checks:
//      pix_cnt: 12-bit, saturates at 4095; increments per emitted pixel; cleared at href_fall.
//      At href_fall in ACTIVE: line_err=1 if pix_cnt!=H_ACTIVE or an odd trailing byte is pending.
//        An odd byte is dropped, never emitted.
//      line_cnt: 12-bit, saturating; increments at each href_fall in ACTIVE.
//      At vs_rise ending ACTIVE: frame_err=1 if line_cnt!=V_ACTIVE.
//  - Outside ACTIVE: no outEn, no line_err/frame_err; counters are held cleared.
//  - Simultaneous events: vs_rise while href_d=1 aborts the line.
//    No line_err is raised for it; frame_err evaluates the lines counted so far.
//  - Reset mid-operation: everything returns to WAIT_VS. The next partial frame and
//    FRAME_SKIP frames are discarded again; frame_cnt returns to 0.
// TESTING
//  1 FRAME_SKIP=2, 4x3 frames, cap_en=1, reset mid-frame
//    -> no outEn until the 4th vs_rise; then 12 outEn per frame.
//  2 Bytes 0xF8,0x1F on one href pair, BYTE_ORDER=0 -> Dout=0xF81F, outEn 2 clk after the 0x1F byte.
//    Same bytes, BYTE_ORDER=1 -> Dout=0x1FF8.
//  3 Line of 7 bytes, H_ACTIVE=4 -> 3 pixels, 1-cycle line_err at href_fall, 7th byte dropped.
//  4 Frame with 2 lines, V_ACTIVE=3 -> frame_err and frame_done pulse together on the next vs_rise.
//  5 cap_en dropped mid-frame -> current frame completes, frame_done fires, frame_cnt +1.
//    No further outEn until cap_en=1 at a later vs_rise, which also fires frame_start.
//  6 frame_cnt preloaded near 0xFFFF via 1 frame -> wraps to 0x0000.
//    Async rst_n pulse mid-line -> outputs 0 immediately.

Source files
------------

// File: rtl/dvp_rgb565_capture.sv
// DVP camera front end: samples PCLK-domain vsync/href/data, skips settling frames,
// packs byte pairs into RGB565 pixels and flags line/frame geometry errors.
module dvp_rgb565_capture #(
    parameter int unsigned FRAME_SKIP     = 10,
    parameter int unsigned H_ACTIVE       = 640,
    parameter int unsigned V_ACTIVE       = 480,
    parameter bit          BYTE_ORDER     = 1'b0,
    // Reset value of frame_cnt; nonzero only to exercise the wrap without 64k frames.
    parameter logic [15:0] FRAME_CNT_INIT = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_data,
    input  logic        cap_en,
    output logic [15:0] Dout,
    output logic        outEn,
    output logic        frame_start,
    output logic        frame_done,
    output logic        line_err,
    output logic        frame_err,
    output logic [15:0] frame_cnt
);

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned PIX_W     = 2 * DATA_W;
    localparam logic [11:0] H_ACT12   = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT12   = 12'(V_ACTIVE);
    localparam logic [15:0] SKIP_LAST = (FRAME_SKIP == 0) ? 16'd0 : 16'(FRAME_SKIP - 1);

    typedef enum logic [1:0] {
        WAIT_VS,
        SKIP,
        ARMED,
        ACTIVE
    } state_t;

    function automatic logic [11:0] sat_inc12(input logic [11:0] v);
        return (v == 12'hFFF) ? v : v + 12'd1;
    endfunction

    function automatic logic [PIX_W-1:0] pack_pair(input logic [DATA_W-1:0] first,
                                                   input logic [DATA_W-1:0] second);
        return BYTE_ORDER ? {second, first} : {first, second};
    endfunction

    state_t              state;
    logic [15:0]         skip_cnt;
    logic [11:0]         line_cnt;
    logic [11:0]         pix_cnt;

    logic                vs_p0;
    logic                vs_p0_d;
    logic                href_p0;
    logic                href_p0_d;
    logic [DATA_W-1:0]   data_p0;

    logic                phase_p1;
    logic [DATA_W-1:0]   first_p1;

    logic                vld_p2;
    logic [PIX_W-1:0]    pix_p2;

    logic                vs_rise;
    logic                href_fall;
    logic                line_en;

    // Stage p0: register the camera bus once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_p0     <= 1'b0;
            vs_p0_d   <= 1'b0;
            href_p0   <= 1'b0;
            href_p0_d <= 1'b0;
        end else begin
            vs_p0     <= cam_vsync;
            vs_p0_d   <= vs_p0;
            href_p0   <= cam_href;
            href_p0_d <= href_p0;
        end
    end

    always_ff @(posedge clk) begin
        data_p0 <= cam_data;
    end

    assign vs_rise   = vs_p0 & ~vs_p0_d;
    assign href_fall = ~href_p0 & href_p0_d;
    // A frame boundary aborts any line in flight, so packing pauses on that cycle.
    assign line_en   = (state == ACTIVE) && !vs_rise;

    // Frame-level control: settling skip, arming and frame bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= WAIT_VS;
            skip_cnt    <= 16'd0;
            line_cnt    <= 12'd0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            frame_cnt   <= FRAME_CNT_INIT;
        end else begin
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            case (state)
                WAIT_VS: begin
                    skip_cnt <= 16'd0;
                    line_cnt <= 12'd0;
                    if (vs_rise) begin
                        state <= (FRAME_SKIP == 0) ? ARMED : SKIP;
                    end
                end
                SKIP: begin
                    line_cnt <= 12'd0;
                    if (vs_rise) begin
                        if (skip_cnt == SKIP_LAST) begin
                            state    <= ARMED;
                            skip_cnt <= 16'd0;
                        end else begin
                            skip_cnt <= skip_cnt + 16'd1;
                        end
                    end
                end
                ARMED: begin
                    line_cnt <= 12'd0;
                    if (vs_rise && cap_en) begin
                        state       <= ACTIVE;
                        frame_start <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (vs_rise) begin
                        frame_done <= 1'b1;
                        frame_err  <= (line_cnt != V_ACT12);
                        frame_cnt  <= frame_cnt + 16'd1;
                        line_cnt   <= 12'd0;
                        if (cap_en) begin
                            frame_start <= 1'b1;
                        end else begin
                            state <= ARMED;
                        end
                    end else if (href_fall) begin
                        line_cnt <= sat_inc12(line_cnt);
                    end
                end
                default: state <= WAIT_VS;
            endcase
        end
    end

    // Stage p1/p2: byte-phase tracking, pixel strobe and per-line checks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_p1 <= 1'b0;
            pix_cnt  <= 12'd0;
            vld_p2   <= 1'b0;
            line_err <= 1'b0;
        end else begin
            vld_p2   <= 1'b0;
            line_err <= 1'b0;
            if (!line_en) begin
                phase_p1 <= 1'b0;
                pix_cnt  <= 12'd0;
            end else if (href_p0) begin
                phase_p1 <= ~phase_p1;
                if (phase_p1) begin
                    vld_p2  <= 1'b1;
                    pix_cnt <= sat_inc12(pix_cnt);
                end
            end else begin
                phase_p1 <= 1'b0;
                if (href_fall) begin
                    // A pending first byte means an odd byte count; it is simply dropped.
                    line_err <= (pix_cnt != H_ACT12) || phase_p1;
                    pix_cnt  <= 12'd0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (line_en && href_p0) begin
            if (!phase_p1) begin
                first_p1 <= data_p0;
            end else begin
                pix_p2 <= pack_pair(first_p1, data_p0);
            end
        end
    end

    assign outEn = vld_p2;
    assign Dout  = vld_p2 ? pix_p2 : '0;

endmodule

// File: tb/tb_dvp_rgb565_capture.sv
// Directed bench for dvp_rgb565_capture: skip/arm sequencing, packing order and latency,
// line/frame error pulses, frame-atomic cap_en, frame counter wrap and async reset.
module tb_dvp_rgb565_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cam_vsync;
    logic        cam_href;
    logic [7:0]  cam_data;
    logic        cap_en;

    logic [15:0] o0_Dout;
    logic        o0_outEn;
    logic        o0_frame_start;
    logic        o0_frame_done;
    logic        o0_line_err;
    logic        o0_frame_err;
    logic [15:0] o0_frame_cnt;

    logic [15:0] o1_Dout;
    logic        o1_outEn;
    logic        o1_frame_start;
    logic        o1_frame_done;
    logic        o1_line_err;
    logic        o1_frame_err;
    logic [15:0] o1_frame_cnt;

    int checks = 0;
    int errors = 0;

    int n_out0    = 0;
    int n_fs0     = 0;
    int n_fd0     = 0;
    int n_le0     = 0;
    int n_fe0     = 0;
    int n_both0   = 0;
    int idle_bad0 = 0;
    logic [15:0] last_dout0 = 16'h0;

    dvp_rgb565_capture #(
        .FRAME_SKIP(2), .H_ACTIVE(4), .V_ACTIVE(3), .BYTE_ORDER(1'b0), .FRAME_CNT_INIT(16'h0000)
    ) u0 (
        .clk(clk), .rst_n(rst_n), .cam_vsync(cam_vsync), .cam_href(cam_href),
        .cam_data(cam_data), .cap_en(cap_en),
        .Dout(o0_Dout), .outEn(o0_outEn), .frame_start(o0_frame_start),
        .frame_done(o0_frame_done), .line_err(o0_line_err), .frame_err(o0_frame_err),
        .frame_cnt(o0_frame_cnt)
    );

    dvp_rgb565_capture #(
        .FRAME_SKIP(0), .H_ACTIVE(4), .V_ACTIVE(3), .BYTE_ORDER(1'b1), .FRAME_CNT_INIT(16'hFFFF)
    ) u1 (
        .clk(clk), .rst_n(rst_n), .cam_vsync(cam_vsync), .cam_href(cam_href),
        .cam_data(cam_data), .cap_en(cap_en),
        .Dout(o1_Dout), .outEn(o1_outEn), .frame_start(o1_frame_start),
        .frame_done(o1_frame_done), .line_err(o1_line_err), .frame_err(o1_frame_err),
        .frame_cnt(o1_frame_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o0_outEn) begin
            n_out0++;
            last_dout0 = o0_Dout;
        end else if (o0_Dout !== 16'h0) begin
            idle_bad0++;
        end
        if (o0_frame_start) n_fs0++;
        if (o0_frame_done) n_fd0++;
        if (o0_line_err) n_le0++;
        if (o0_frame_err) n_fe0++;
        if (o0_frame_done && o0_frame_err) n_both0++;
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic vs_hi();
        cam_vsync = 1'b1;
        cyc();
        cyc();
    endtask

    task automatic vs_lo();
        cam_vsync = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic vsync();
        vs_hi();
        vs_lo();
    endtask

    task automatic send_line(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            cam_href = 1'b1;
            cam_data = base + 8'(i);
            cyc();
        end
        cam_href = 1'b0;
        cam_data = 8'h00;
        repeat (3) cyc();
    endtask

    task automatic good_frame();
        send_line(8, 8'h00);
        send_line(8, 8'h10);
        send_line(8, 8'h20);
    endtask

    initial begin
        rst_n     = 1'b0;
        cam_vsync = 1'b0;
        cam_href  = 1'b0;
        cam_data  = 8'h00;
        cap_en    = 1'b1;
        repeat (3) cyc();

        check("rst_dout", 32'(o0_Dout), 32'h0);
        check("rst_outen", 32'(o0_outEn), 32'h0);
        check("rst_fstart", 32'(o0_frame_start), 32'h0);
        check("rst_fdone", 32'(o0_frame_done), 32'h0);
        check("rst_lerr", 32'(o0_line_err), 32'h0);
        check("rst_ferr", 32'(o0_frame_err), 32'h0);
        check("rst_fcnt", 32'(o0_frame_cnt), 32'h0);

        // Power-up partial frame, then a reset in the middle of a line
        rst_n = 1'b1;
        cyc();
        send_line(8, 8'h40);
        vsync();
        send_line(8, 8'h50);
        cam_href = 1'b1;
        cam_data = 8'h60;
        cyc();
        cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cam_href = 1'b0;
        cyc();
        cyc();
        check("pre_out_none", 32'(n_out0), 32'd0);

        // Partial frame plus two settling frames are discarded
        vsync();
        good_frame();
        vsync();
        good_frame();
        vsync();
        check("u1_fcnt_wrap", 32'(o1_frame_cnt), 32'h0000);
        good_frame();
        check("skip_out_none", 32'(n_out0), 32'd0);
        check("skip_fs_none", 32'(n_fs0), 32'd0);

        // Fourth vs_rise starts the first captured frame
        vs_hi();
        check("first_fstart", 32'(o0_frame_start), 32'h1);
        vs_lo();
        good_frame();
        check("frameD_pix", 32'(n_out0), 32'd12);
        check("frameD_lerr", 32'(n_le0), 32'd0);
        check("frameD_last", 32'(last_dout0), 32'h2627);

        vs_hi();
        check("v5_fdone", 32'(o0_frame_done), 32'h1);
        check("v5_ferr", 32'(o0_frame_err), 32'h0);
        check("v5_fstart", 32'(o0_frame_start), 32'h1);
        check("v5_fcnt", 32'(o0_frame_cnt), 32'd1);
        vs_lo();

        // Single byte pair: packing order and latency
        cam_href = 1'b1;
        cam_data = 8'hF8;
        cyc();
        cam_data = 8'h1F;
        cyc();
        check("pair_early", 32'(o0_outEn), 32'h0);
        cam_href = 1'b0;
        cam_data = 8'h00;
        cyc();
        check("pair_outen", 32'(o0_outEn), 32'h1);
        check("pair_dout_bo0", 32'(o0_Dout), 32'hF81F);
        check("pair_dout_bo1", 32'(o1_Dout), 32'h1FF8);
        cyc();
        check("pair_outen_off", 32'(o0_outEn), 32'h0);
        check("pair_dout_off", 32'(o0_Dout), 32'h0);
        check("pair_lerr", 32'(o0_line_err), 32'h1);
        cyc();
        check("pair_lerr_off", 32'(o0_line_err), 32'h0);
        cyc();

        // Seven-byte line: three pixels, trailing byte dropped
        send_line(7, 8'h10);
        check("odd_pix", 32'(n_out0), 32'd16);
        check("odd_lerr", 32'(n_le0), 32'd2);
        check("odd_last", 32'(last_dout0), 32'h1415);

        // Only two lines in this frame
        vs_hi();
        check("v6_fdone", 32'(o0_frame_done), 32'h1);
        check("v6_ferr", 32'(o0_frame_err), 32'h1);
        check("v6_fcnt", 32'(o0_frame_cnt), 32'd2);
        vs_lo();
        check("v6_both", 32'(n_both0), 32'd1);
        check("v6_fe_once", 32'(n_fe0), 32'd1);

        // cap_en dropped mid-frame: current frame still completes
        send_line(8, 8'h00);
        cap_en = 1'b0;
        send_line(8, 8'h10);
        send_line(8, 8'h20);
        check("capoff_pix", 32'(n_out0), 32'd28);
        vs_hi();
        check("v7_fdone", 32'(o0_frame_done), 32'h1);
        check("v7_fstart", 32'(o0_frame_start), 32'h0);
        check("v7_ferr", 32'(o0_frame_err), 32'h0);
        check("v7_fcnt", 32'(o0_frame_cnt), 32'd3);
        vs_lo();

        // Armed but idle; raising cap_en mid-frame changes nothing yet
        send_line(8, 8'h00);
        cap_en = 1'b1;
        send_line(8, 8'h10);
        send_line(8, 8'h20);
        check("armed_pix", 32'(n_out0), 32'd28);
        check("armed_fs", 32'(n_fs0), 32'd3);
        vs_hi();
        check("v8_fstart", 32'(o0_frame_start), 32'h1);
        check("v8_fdone", 32'(o0_frame_done), 32'h0);
        vs_lo();
        good_frame();
        check("frameH_pix", 32'(n_out0), 32'd40);
        vs_hi();
        check("v9_fcnt", 32'(o0_frame_cnt), 32'd4);
        vs_lo();
        check("tot_fdone", 32'(n_fd0), 32'd4);
        check("tot_fstart", 32'(n_fs0), 32'd5);
        check("tot_lerr", 32'(n_le0), 32'd2);
        check("tot_ferr", 32'(n_fe0), 32'd1);

        // Asynchronous reset while a pixel is on the output
        cam_href = 1'b1;
        cam_data = 8'hA0;
        cyc();
        cam_data = 8'hA1;
        cyc();
        cam_data = 8'hA2;
        cyc();
        check("arst_pre_outen", 32'(o0_outEn), 32'h1);
        check("arst_pre_dout", 32'(o0_Dout), 32'hA0A1);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_outen", 32'(o0_outEn), 32'h0);
        check("arst_dout", 32'(o0_Dout), 32'h0);
        check("arst_fcnt", 32'(o0_frame_cnt), 32'h0);
        cam_href = 1'b0;
        cam_data = 8'h00;
        cyc();
        rst_n = 1'b1;
        cyc();

        // After reset the partial frame is discarded again
        vsync();
        good_frame();
        vsync();
        good_frame();
        check("post_rst_pix", 32'(n_out0), 32'd40);
        check("idle_dout_zero", 32'(idle_bad0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
